uart_tx_fifo: RTL and testbench

Parametrised UART transmitter, the successor to the single-byte fixed-8N1 transmitter. It serialises frames with configurable data width, stop-bit count and optional parity. A small internal FIFO decouples the producer from the line, so frames go out back-to-back with no idle gap. It sits between the SoC-side byte producer (valid/ready) and the board TX pin.

---
 rtl/uart_tx_fifo.sv | 264 ++++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Parametrised UART transmitter fed by a small FIFO. Frames are
//               start bit, DATA_BITS data bits (LSB first), optional parity
//               bit and STOP_BITS stop bits. Queued words go out back-to-back
//               with no idle gap between frames.
//
// Parameters  : CLK_PER_BAUD  clocks per bit period (>=1)
//               DATA_BITS     data bits per frame (5..9)
//               STOP_BITS     stop bits per frame (1 or 2)
//               FIFO_DEPTH    FIFO entries (power of 2, >=2)
//
// Ports       : clk          clock, rising edge
//               rst          asynchronous reset, active low
//               tx_data      word to send
//               tx_valid     producer offers tx_data
//               tx_ready     FIFO not full (accept when valid & ready)
//               parity_mode  0 none, 1 even, 2 odd, 3 none
//               tx           registered serial line, idle high
//               busy         transmitter active or words queued
//               done         one-cycle pulse in the last clock of a frame
//               fifo_level   current FIFO occupancy
//
// Build macro : UART_TX_FIFO_PARITY_EN - when defined, parity_mode is stored
//               with each word and the parity bit is transmitted; when
//               undefined, parity_mode is ignored and no parity bit is sent.
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int CLK_PER_BAUD = 1,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [DATA_BITS-1:0]                 tx_data,
   input  logic                                 tx_valid,
   output logic                                 tx_ready,
   input  logic [1:0]                           parity_mode,
   output logic                                 tx,
   output logic                                 busy,
   output logic                                 done,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level
);

   localparam int c_lw = $clog2(FIFO_DEPTH + 1);
   localparam int c_pw = $clog2(FIFO_DEPTH);
   localparam int c_bw = (CLK_PER_BAUD > 1) ? $clog2(CLK_PER_BAUD) : 1;
`ifdef UART_TX_FIFO_PARITY_EN
   localparam int c_ew = DATA_BITS + 2;
`else
   localparam int c_ew = DATA_BITS;
`endif

   localparam logic [c_lw-1:0] c_full      = c_lw'(FIFO_DEPTH);
   localparam logic [c_lw-1:0] c_lvl_one   = c_lw'(1);
   localparam logic [c_pw-1:0] c_ptr_one   = c_pw'(1);
   localparam logic [c_bw-1:0] c_baud_last = c_bw'(CLK_PER_BAUD - 1);
   localparam logic [c_bw-1:0] c_baud_one  = c_bw'(1);
   localparam logic [3:0]      c_data_last = 4'(DATA_BITS - 1);
   localparam logic [3:0]      c_stop_last = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // ------------------------------------------------------------------------
   // FIFO storage and pointers
   // ------------------------------------------------------------------------
   logic [c_ew-1:0]      r_mem [FIFO_DEPTH];
   logic [c_pw-1:0]      r_wr_ptr;
   logic [c_pw-1:0]      r_rd_ptr;
   logic [c_lw-1:0]      r_level;

   logic                 w_push;
   logic                 w_pop;
   logic                 w_nonempty;
   logic [c_ew-1:0]      w_push_word;
   logic [c_ew-1:0]      w_head;
   logic [DATA_BITS-1:0] w_head_data;
   logic                 w_head_par_en;
   logic                 w_head_par_bit;

   assign tx_ready   = (r_level != c_full);
   assign w_push     = tx_valid && tx_ready;
   assign w_nonempty = (r_level != '0);
   assign w_head     = r_mem[r_rd_ptr];
   assign w_head_data = w_head[DATA_BITS-1:0];

`ifdef UART_TX_FIFO_PARITY_EN
   logic [1:0] w_head_mode;
   assign w_push_word    = {parity_mode, tx_data};
   assign w_head_mode    = w_head[DATA_BITS +: 2];
   assign w_head_par_en  = (w_head_mode == 2'd1) || (w_head_mode == 2'd2);
   // Even parity is the XOR of the data bits; odd parity inverts it.
   assign w_head_par_bit = (^w_head_data) ^ (w_head_mode == 2'd2);
`else
   logic w_unused_parity;
   assign w_push_word     = tx_data;
   assign w_head_par_en   = 1'b0;
   assign w_head_par_bit  = 1'b0;
   assign w_unused_parity = ^parity_mode;
`endif

   // Storage has no reset: contents are meaningless once the pointers clear.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_push_word;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + c_lvl_one;
            2'b01:   r_level <= r_level - c_lvl_one;
            default: r_level <= r_level;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Transmit FSM
   // ------------------------------------------------------------------------
   state_t               r_state;
   logic [c_bw-1:0]      r_baud_cnt;
   logic [3:0]           r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_en;
   logic                 r_par_bit;
   logic                 r_tx;
   logic                 r_done;

   logic                 w_bit_end;
   logic                 w_frame_end;

   assign w_bit_end   = (r_baud_cnt == c_baud_last);
   assign w_frame_end = (r_state == S_STOP) && w_bit_end && (r_bit_cnt == c_stop_last);
   // Pop from IDLE, or straight out of the last stop bit for a zero-gap frame.
   assign w_pop       = w_nonempty && ((r_state == S_IDLE) || w_frame_end);

   // tx is registered from the current state, so the line trails the state
   // register by one clock; done is registered alongside it and therefore
   // lines up with the final clock of the last stop bit on the line.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_par_en   <= 1'b0;
         r_par_bit  <= 1'b0;
         r_tx       <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_tx       <= 1'b1;
               r_baud_cnt <= '0;
               if (w_pop) begin
                  r_shift   <= w_head_data;
                  r_par_en  <= w_head_par_en;
                  r_par_bit <= w_head_par_bit;
                  r_bit_cnt <= '0;
                  r_state   <= S_START;
               end
            end

            S_START: begin
               r_tx <= 1'b0;
               if (w_bit_end) begin
                  r_baud_cnt <= '0;
                  r_state    <= S_DATA;
               end else begin
                  r_baud_cnt <= r_baud_cnt + c_baud_one;
               end
            end

            S_DATA: begin
               r_tx <= r_shift[0];
               if (w_bit_end) begin
                  r_baud_cnt <= '0;
                  r_shift    <= r_shift >> 1;
                  if (r_bit_cnt == c_data_last) begin
                     r_bit_cnt <= '0;
                     r_state   <= r_par_en ? S_PARITY : S_STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + c_baud_one;
               end
            end

            S_PARITY: begin
               r_tx <= r_par_bit;
               if (w_bit_end) begin
                  r_baud_cnt <= '0;
                  r_state    <= S_STOP;
               end else begin
                  r_baud_cnt <= r_baud_cnt + c_baud_one;
               end
            end

            S_STOP: begin
               r_tx <= 1'b1;
               if (w_bit_end) begin
                  r_baud_cnt <= '0;
                  if (r_bit_cnt == c_stop_last) begin
                     r_bit_cnt <= '0;
                     r_done    <= 1'b1;
                     if (w_pop) begin
                        r_shift   <= w_head_data;
                        r_par_en  <= w_head_par_en;
                        r_par_bit <= w_head_par_bit;
                        r_state   <= S_START;
                     end else begin
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + c_baud_one;
               end
            end

            default: begin
               r_tx       <= 1'b1;
               r_baud_cnt <= '0;
               r_bit_cnt  <= '0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   assign tx         = r_tx;
   assign done       = r_done;
   assign fifo_level = r_level;
   // r_done keeps busy high through the final line clock, so busy falls on
   // the edge after done when nothing is queued.
   assign busy       = (r_state != S_IDLE) || w_nonempty || r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Directed self-checking bench for uart_tx_fifo. Instance A is
//               8N1 at 4 clocks per bit; instance B is 5 data bits, 2 stop
//               bits at 2 clocks per bit. Expected line patterns are written
//               as frame bit vectors (bit 0 = start bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

   logic       clk;
   logic       rst;

   logic [7:0] a_data;
   logic       a_valid;
   logic       a_ready;
   logic [1:0] a_mode;
   logic       a_tx;
   logic       a_busy;
   logic       a_done;
   logic [2:0] a_level;

   logic [4:0] b_data;
   logic       b_valid;
   logic       b_ready;
   logic [1:0] b_mode;
   logic       b_tx;
   logic       b_busy;
   logic       b_done;
   logic [2:0] b_level;

   int         n_cmp;
   int         n_err;
   int         sent;
   logic [9:0] frm;
   logic       exp_tx;
   logic       exp_done;
   logic [7:0] words [6];

   uart_tx_fifo #(
      .CLK_PER_BAUD (4),
      .DATA_BITS    (8),
      .STOP_BITS    (1),
      .FIFO_DEPTH   (4)
   ) u_dut_a (
      .clk         (clk),
      .rst         (rst),
      .tx_data     (a_data),
      .tx_valid    (a_valid),
      .tx_ready    (a_ready),
      .parity_mode (a_mode),
      .tx          (a_tx),
      .busy        (a_busy),
      .done        (a_done),
      .fifo_level  (a_level)
   );

   uart_tx_fifo #(
      .CLK_PER_BAUD (2),
      .DATA_BITS    (5),
      .STOP_BITS    (2),
      .FIFO_DEPTH   (4)
   ) u_dut_b (
      .clk         (clk),
      .rst         (rst),
      .tx_data     (b_data),
      .tx_valid    (b_valid),
      .tx_ready    (b_ready),
      .parity_mode (b_mode),
      .tx          (b_tx),
      .busy        (b_busy),
      .done        (b_done),
      .fifo_level  (b_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish, expected finish before 100000");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sends one word to an idle DUT and checks the line clock by clock.
   // Called at a negedge; returns at the negedge after busy should drop.
   task automatic send_frame(input bit use_b, input string tag, input logic [8:0] data,
                             input logic [1:0] mode, input logic [15:0] bits,
                             input int nbits, input int cpb);
      if (use_b) begin
         b_data  = data[4:0];
         b_valid = 1'b1;
      end else begin
         a_data  = data[7:0];
         a_mode  = mode;
         a_valid = 1'b1;
      end
      @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b0;
      check({tag, "_level"}, use_b ? b_level : a_level, 32'd1);
      check({tag, "_busy"}, use_b ? b_busy : a_busy, 32'd1);
      @(negedge clk);
      check({tag, "_latency"}, use_b ? b_tx : a_tx, 32'd1);
      for (int k = 1; k <= nbits * cpb; k++) begin
         @(negedge clk);
         check({tag, "_tx"}, use_b ? b_tx : a_tx, bits[(k - 1) / cpb]);
         check({tag, "_done"}, use_b ? b_done : a_done, (k == nbits * cpb));
      end
      @(negedge clk);
      check({tag, "_idle_tx"}, use_b ? b_tx : a_tx, 32'd1);
      check({tag, "_idle_done"}, use_b ? b_done : a_done, 32'd0);
      check({tag, "_idle_busy"}, use_b ? b_busy : a_busy, 32'd0);
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      rst     = 1'b0;
      a_data  = '0;
      a_valid = 1'b0;
      a_mode  = 2'd0;
      b_data  = '0;
      b_valid = 1'b0;
      b_mode  = 2'd0;
      words[0] = 8'h01;
      words[1] = 8'h80;
      words[2] = 8'hA5;
      words[3] = 8'h3C;
      words[4] = 8'hFF;
      words[5] = 8'h00;

      // Reset values, checked while held and after release.
      repeat (3) @(negedge clk);
      check("rst_tx", a_tx, 32'd1);
      check("rst_ready", a_ready, 32'd1);
      check("rst_busy", a_busy, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_tx", a_tx, 32'd1);
      check("post_rst_ready", a_ready, 32'd1);
      check("post_rst_done", a_done, 32'd0);
      check("post_rst_busy", a_busy, 32'd0);
      check("post_rst_level", a_level, 32'd0);
      check("post_rst_b_tx", b_tx, 32'd1);
      check("post_rst_b_ready", b_ready, 32'd1);
      check("post_rst_b_level", b_level, 32'd0);

      // 8N1, 0x55: 0,1,0,1,0,1,0,1,0,1 each for 4 clocks, done in clock 40.
      send_frame(1'b0, "f55", 9'h055, 2'd0, 16'h02AA, 10, 4);

`ifdef UART_TX_FIFO_PARITY_EN
      // 0x07 even parity -> parity bit 1; odd -> 0; mode 3 -> no parity bit.
      send_frame(1'b0, "even07", 9'h007, 2'd1, 16'h060E, 11, 4);
      send_frame(1'b0, "odd07", 9'h007, 2'd2, 16'h040E, 11, 4);
      send_frame(1'b0, "mode3_07", 9'h007, 2'd3, 16'h020E, 10, 4);
`else
      // Parity disabled in this build: mode is ignored, frame stays 10 bits.
      send_frame(1'b0, "nopar07", 9'h007, 2'd1, 16'h020E, 10, 4);
`endif
      a_mode = 2'd0;

      // 5 data bits, 2 stop bits, 2 clocks per bit: 0,1,1,1,1,1,1,1 over 16 clocks.
      send_frame(1'b1, "b1f", 9'h01F, 2'd0, 16'h00FE, 8, 2);

      // Burst: valid held from idle. First word accepted at the edge after
      // c=0, tx low observed from c=3, six contiguous 40-clock frames.
      sent = 0;
      for (int c = 0; c <= 243; c++) begin
         exp_tx   = 1'b1;
         exp_done = 1'b0;
         if (c >= 3 && c < 243) begin
            frm      = {1'b1, words[(c - 3) / 40], 1'b0};
            exp_tx   = frm[((c - 3) % 40) / 4];
            exp_done = (((c - 3) % 40) == 39);
         end
         check("burst_tx", a_tx, exp_tx);
         check("burst_done", a_done, exp_done);
         if (c == 242) begin
            check("burst_busy_last", a_busy, 32'd1);
         end
         if (c == 5) begin
            check("burst_full_level", a_level, 32'd4);
         end
         if (sent < 6) begin
            check("burst_ready", a_ready, ((c < 5) || (c >= 42)));
            a_valid = 1'b1;
            a_data  = words[sent];
            if (a_ready) begin
               sent++;
            end
         end else begin
            a_valid = 1'b0;
         end
         @(negedge clk);
      end
      check("burst_sent", sent, 32'd6);
      check("burst_end_busy", a_busy, 32'd0);
      check("burst_end_level", a_level, 32'd0);

      // Reset mid-frame with two words queued behind the active one.
      a_valid = 1'b1;
      a_data  = 8'h00;
      @(negedge clk);
      a_data  = 8'h11;
      @(negedge clk);
      a_data  = 8'h22;
      @(negedge clk);
      a_valid = 1'b0;
      check("pre_rst_level", a_level, 32'd2);
      repeat (10) @(negedge clk);
      check("pre_rst_tx", a_tx, 32'd0);
      rst = 1'b0;
      #1;
      check("async_rst_tx", a_tx, 32'd1);
      check("async_rst_level", a_level, 32'd0);
      check("async_rst_busy", a_busy, 32'd0);
      check("async_rst_ready", a_ready, 32'd1);
      check("async_rst_done", a_done, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         check("after_rst_tx", a_tx, 32'd1);
         check("after_rst_busy", a_busy, 32'd0);
      end
      check("after_rst_level", a_level, 32'd0);
      check("after_rst_b_busy", b_busy, 32'd0);
      check("after_rst_b_done", b_done, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
